// File: rtl/cr_biu_lpmd_drain.sv
// cr_biu_lpmd_drain: blocks new BIU requests on a CP0 low-power request, waits for a quiet bus window, then acks
//   lpmd_sm_clk / cpurst_b : gated state clock, async active-low reset
//   cp0_cache_lpmd_req     : level low-power request from the CP0 sequencer
//   iu_yy_xx_flush         : pipeline flush, aborts any drain
//   biu_lpmd_idle          : BIU has no outstanding traffic and an empty write buffer
//   cache_cp0_lpmd_ack     : drain complete, safe to enter low power
//   cache_biu_lpmd_block   : BIU must not grant new requests
//   lpmd_drain_busy        : drain in progress (BLOCK or QUIET)
//   lpmd_drain_timeout     : sticky flag, drain ran for 2^TO_W-1 cycles
module cr_biu_lpmd_drain #(
    parameter int QUIET_CYC = 2,
    parameter int TO_W      = 8
) (
    input  logic lpmd_sm_clk,
    input  logic cpurst_b,
    input  logic cp0_cache_lpmd_req,
    input  logic iu_yy_xx_flush,
    input  logic biu_lpmd_idle,
    output logic cache_cp0_lpmd_ack,
    output logic cache_biu_lpmd_block,
    output logic lpmd_drain_busy,
    output logic lpmd_drain_timeout
);
    typedef enum logic [1:0] {IDLE, BLOCK, QUIET, ACK} state_t;
    localparam logic [3:0] QLAST = 4'(QUIET_CYC - 1);
    state_t state, state_nxt;
    logic [3:0] qcnt, qcnt_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;
    logic run;
    // flush and a dropped request both collapse to IDLE with counters cleared
    assign run = cp0_cache_lpmd_req && !iu_yy_xx_flush;
    always_comb begin
        state_nxt = IDLE;
        qcnt_nxt  = '0;
        tcnt_nxt  = '0;
        if (run) begin
            case (state)
                IDLE:    state_nxt = BLOCK;
                BLOCK:   state_nxt = biu_lpmd_idle ? QUIET : BLOCK;
                QUIET: begin
                    state_nxt = !biu_lpmd_idle ? BLOCK : (qcnt == QLAST) ? ACK : QUIET;
                    qcnt_nxt  = (biu_lpmd_idle && qcnt != QLAST) ? qcnt + 4'd1 : '0;
                end
                default: state_nxt = ACK;
            endcase
            // counts BLOCK/QUIET cycles, saturates, holds through ACK
            tcnt_nxt = (state == IDLE) ? '0 : (state == ACK || &tcnt) ? tcnt : tcnt + TO_W'(1);
        end
    end
    always_ff @(posedge lpmd_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state              <= IDLE;
            qcnt               <= '0;
            tcnt               <= '0;
            lpmd_drain_timeout <= 1'b0;
        end else begin
            state              <= state_nxt;
            qcnt               <= qcnt_nxt;
            tcnt               <= tcnt_nxt;
            lpmd_drain_timeout <= lpmd_drain_timeout | (&tcnt_nxt);
        end
    end
    // ack is gated by the live request so it falls in the same cycle req does
    assign cache_cp0_lpmd_ack   = (state == ACK) && cp0_cache_lpmd_req;
    assign cache_biu_lpmd_block = (state != IDLE);
    assign lpmd_drain_busy      = (state == BLOCK) || (state == QUIET);
endmodule

// File: tb/tb_cr_biu_lpmd_drain.sv
// tb_cr_biu_lpmd_drain: scoreboard bench for the low-power drain unit (QUIET_CYC=2, TO_W=4)
module tb_cr_biu_lpmd_drain;
    logic lpmd_sm_clk = 1'b0;
    logic cpurst_b = 1'b0;
    logic req = 1'b0;
    logic flush = 1'b0;
    logic idle = 1'b0;
    logic ack, block, busy, tmo;
    logic [3:0] obs;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t cur;

    always #5 lpmd_sm_clk = ~lpmd_sm_clk;

    cr_biu_lpmd_drain #(.QUIET_CYC(2), .TO_W(4)) dut (
        .lpmd_sm_clk          (lpmd_sm_clk),
        .cpurst_b             (cpurst_b),
        .cp0_cache_lpmd_req   (req),
        .iu_yy_xx_flush       (flush),
        .biu_lpmd_idle        (idle),
        .cache_cp0_lpmd_ack   (ack),
        .cache_biu_lpmd_block (block),
        .lpmd_drain_busy      (busy),
        .lpmd_drain_timeout   (tmo)
    );

    assign obs = {ack, block, busy, tmo};

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (ack,block,busy,timeout)", tag, got, exp);
        end
    endtask

    always @(negedge lpmd_sm_clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk(cur.tag, obs, cur.exp);
        end
    end

    task automatic cyc(input string tag, input logic r, input logic f, input logic i, input logic [3:0] exp);
        sb_t e;
        req   = r;
        flush = f;
        idle  = i;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(negedge lpmd_sm_clk);
        @(posedge lpmd_sm_clk);
        #1;
    endtask

    initial begin
        #12;
        chk("in reset", obs, 4'b0000);
        cpurst_b = 1'b1;
        @(posedge lpmd_sm_clk);
        #1;
        cyc("idle", 0, 0, 0, 4'b0000);
        // basic drain
        cyc("basic c0", 1, 0, 1, 4'b0000);
        for (int k = 1; k <= 3; k++) cyc($sformatf("basic c%0d", k), 1, 0, 1, 4'b0110);
        cyc("basic c4 ack", 1, 0, 1, 4'b1100);
        cyc("basic c5 req drop", 0, 0, 1, 4'b0100);
        cyc("basic c6", 0, 0, 1, 4'b0000);
        // outstanding traffic
        cyc("busbusy c0", 1, 0, 0, 4'b0000);
        for (int k = 1; k <= 6; k++) cyc($sformatf("busbusy c%0d", k), 1, 0, 0, 4'b0110);
        for (int k = 7; k <= 9; k++) cyc($sformatf("busbusy c%0d", k), 1, 0, 1, 4'b0110);
        cyc("busbusy c10 ack", 1, 0, 1, 4'b1100);
        cyc("busbusy c11", 0, 0, 1, 4'b0100);
        cyc("busbusy c12", 0, 0, 1, 4'b0000);
        // quiet window interrupted at qcnt=1
        cyc("qint c0", 1, 0, 1, 4'b0000);
        cyc("qint c1", 1, 0, 1, 4'b0110);
        cyc("qint c2", 1, 0, 1, 4'b0110);
        cyc("qint c3 drop", 1, 0, 0, 4'b0110);
        for (int k = 4; k <= 6; k++) cyc($sformatf("qint c%0d", k), 1, 0, 1, 4'b0110);
        cyc("qint c7 ack", 1, 0, 1, 4'b1100);
        cyc("qint c8", 0, 0, 1, 4'b0100);
        cyc("qint c9", 0, 0, 1, 4'b0000);
        // flush in QUIET together with an idle drop, then restart
        cyc("flush c0", 1, 0, 1, 4'b0000);
        cyc("flush c1", 1, 0, 1, 4'b0110);
        cyc("flush c2", 1, 0, 1, 4'b0110);
        cyc("flush c3", 1, 1, 0, 4'b0110);
        cyc("flush c4 idle", 1, 0, 1, 4'b0000);
        for (int k = 5; k <= 7; k++) cyc($sformatf("flush c%0d", k), 1, 0, 1, 4'b0110);
        cyc("flush c8 ack", 1, 0, 1, 4'b1100);
        cyc("flush c9", 0, 0, 1, 4'b0100);
        cyc("flush c10", 0, 0, 1, 4'b0000);
        // timeout with a stuck bus
        cyc("tmo c0", 1, 0, 0, 4'b0000);
        for (int k = 1; k <= 15; k++) cyc($sformatf("tmo c%0d", k), 1, 0, 0, 4'b0110);
        for (int k = 16; k <= 18; k++) cyc($sformatf("tmo c%0d", k), 1, 0, 0, 4'b0111);
        for (int k = 19; k <= 21; k++) cyc($sformatf("tmo c%0d", k), 1, 0, 1, 4'b0111);
        cyc("tmo c22 ack", 1, 0, 1, 4'b1101);
        cyc("tmo c23", 0, 0, 1, 4'b0101);
        cyc("tmo c24 sticky", 0, 0, 1, 4'b0001);
        cyc("tmo c25 flush", 0, 1, 1, 4'b0001);
        cyc("tmo c26 sticky", 0, 0, 0, 4'b0001);
        // reset while acking; idle ignored in ACK
        cyc("rst c0", 1, 0, 1, 4'b0001);
        for (int k = 1; k <= 3; k++) cyc($sformatf("rst c%0d", k), 1, 0, 1, 4'b0111);
        cyc("rst c4 ack", 1, 0, 0, 4'b1101);
        chk("ack held idle low", obs, 4'b1101);
        cpurst_b = 1'b0;
        #1;
        chk("async reset", obs, 4'b0000);
        req = 1'b0;
        @(negedge lpmd_sm_clk);
        cpurst_b = 1'b1;
        @(posedge lpmd_sm_clk);
        #1;
        for (int k = 0; k < 3; k++) cyc($sformatf("post rst %0d", k), 0, 0, 1, 4'b0000);
        chk("scoreboard empty", 4'(sb.size()), 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
